// File: rtl/dma_lite_write_ctrl_pkg.sv
// Shared definitions for the AXI DMA register-programming logic.
// Contents:
//   - channel base offsets (MM2S at 0x00, S2MM at 0x30)
//   - register offsets relative to a channel base (DMACR, DMASR, SA, DA, LENGTH)
//   - AXI response codes
//   - one-hot state encoding for the write controller
//   - reg_offset(): absolute register offset for write slot 0/1/2 of a channel
package dma_lite_write_ctrl_pkg;

  localparam logic [9:0] CH_BASE_MM2S = 10'h000;
  localparam logic [9:0] CH_BASE_S2MM = 10'h030;

  localparam logic [9:0] REG_DMACR  = 10'h000;
  localparam logic [9:0] REG_DMASR  = 10'h004;
  localparam logic [9:0] REG_SA     = 10'h018;
  localparam logic [9:0] REG_DA     = 10'h018;
  localparam logic [9:0] REG_LENGTH = 10'h028;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [5:0] {
    ST_IDLE  = 6'b000001,
    ST_ISSUE = 6'b000010,
    ST_RESP  = 6'b000100,
    ST_NEXT  = 6'b001000,
    ST_FIN   = 6'b010000,
    ST_FAIL  = 6'b100000
  } state_e;

  // Slot 0 is the control register, slot 1 the buffer address (SA for
  // MM2S, DA for S2MM), slot 2 the length register that kicks the DMA off.
  function automatic logic [9:0] reg_offset(input logic s2mm, input logic [1:0] idx);
    logic [9:0] base;
    base = s2mm ? CH_BASE_S2MM : CH_BASE_MM2S;
    case (idx)
      2'd0:    return base + REG_DMACR;
      2'd1:    return base + (s2mm ? REG_DA : REG_SA);
      default: return base + REG_LENGTH;
    endcase
  endfunction

endpackage

// File: rtl/dma_lite_write_ctrl_if.sv
// AXI4-Lite write-only bus (AW, W, B channels) between the DMA write
// controller and the register slave.
// Signals:
//   awaddr/awvalid/awready  write address channel (10-bit register offset)
//   wdata/wstrb/wvalid/wready  write data channel
//   bresp/bvalid/bready     write response channel
// Modports: master drives AW/W and bready; slave drives readies and B.
interface dma_lite_write_ctrl_if;

  logic [9:0]  awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  awready, wready, bresp, bvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output awready, wready, bresp, bvalid
  );

endinterface

// File: rtl/dma_lite_write_ctrl.sv
// AXI4-Lite write master that programs one AXI DMA channel for a single
// simple-mode transfer: DMACR, then SA/DA, then LENGTH (last, as it starts
// the transfer). An error response aborts the remaining writes.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   start             one-cycle request, accepted only while idle
//   buf_addr, buf_len buffer address and byte count, latched on accept
//   m_axi_lite        AXI4-Lite write master (AW/W/B)
//   busy              high while a sequence is in flight
//   done, err         one-cycle completion / failure pulses
module dma_lite_write_ctrl
  import dma_lite_write_ctrl_pkg::*;
#(
  parameter bit          CH_S2MM  = 1'b1,
  parameter logic [31:0] CR_VALUE = 32'h0000_0001,
  parameter int          LEN_W    = 26
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [31:0]          buf_addr,
  input  logic [LEN_W-1:0]     buf_len,
  dma_lite_write_ctrl_if.master m_axi_lite,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  state_e            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;
  logic              awvalid_q, awvalid_d;
  logic              wvalid_q, wvalid_d;
  logic [9:0]        awaddr_q, awaddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              aw_hs;
  logic              w_hs;
  logic [1:0]        idx_nxt;
  logic [31:0]       len_ext;

  assign aw_hs   = awvalid_q & m_axi_lite.awready;
  assign w_hs    = wvalid_q & m_axi_lite.wready;
  assign idx_nxt = idx_q + 2'd1;
  assign len_ext = 32'(len_q);

  // State and datapath registers; everything clears on reset so the bus
  // goes quiet immediately, including address and data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Next-state logic. Both valids are raised together when a write is
  // loaded; each drops on its own handshake, and the response phase only
  // begins once both channels have been accepted.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    addr_d    = addr_q;
    len_d     = len_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d    = buf_addr;
          len_d     = buf_len;
          idx_d     = 2'd0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          awaddr_d  = reg_offset(CH_S2MM, 2'd0);
          wdata_d   = CR_VALUE;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if (aw_done_q && w_done_q) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (m_axi_lite.bvalid) begin
          state_d = (m_axi_lite.bresp == RESP_OKAY) ? ST_NEXT : ST_FAIL;
        end
      end
      ST_NEXT: begin
        if (idx_q == 2'd2) begin
          state_d = ST_FIN;
        end else begin
          idx_d     = idx_nxt;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          awaddr_d  = reg_offset(CH_S2MM, idx_nxt);
          wdata_d   = (idx_nxt == 2'd1) ? addr_q : len_ext;
          state_d   = ST_ISSUE;
        end
      end
      ST_FIN: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      ST_FAIL: begin
        err_d   = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign m_axi_lite.awaddr  = awaddr_q;
  assign m_axi_lite.awvalid = awvalid_q;
  assign m_axi_lite.wdata   = wdata_q;
  assign m_axi_lite.wstrb   = wvalid_q ? 4'hF : 4'h0;
  assign m_axi_lite.wvalid  = wvalid_q;
  assign m_axi_lite.bready  = (state_q == ST_RESP);

  // done/err are registered off FIN/FAIL so they land in the first idle
  // cycle, which keeps them disjoint from busy.
  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_dma_lite_write_ctrl.sv
// Directed testbench for dma_lite_write_ctrl. Two instances (S2MM and
// MM2S) share one behavioural AXI4-Lite slave through a select mux; the
// slave has programmable AW/W ready delays, early B response and a one-shot
// error injection, and logs every accepted address and data beat.
module tb_dma_lite_write_ctrl;
  import dma_lite_write_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] bufAddr;
  logic [25:0] bufLen;
  logic        sel;

  logic busy0, done0, err0;
  logic busy1, done1, err1;

  dma_lite_write_ctrl_if bus0 ();
  dma_lite_write_ctrl_if bus1 ();

  always #5 clk = ~clk;

  dma_lite_write_ctrl #(.CH_S2MM(1'b1), .CR_VALUE(32'h0000_0001), .LEN_W(26)) dutS2mm (
    .clk(clk), .rst_n(rst_n), .start(start & ~sel), .buf_addr(bufAddr), .buf_len(bufLen),
    .m_axi_lite(bus0), .busy(busy0), .done(done0), .err(err0)
  );

  dma_lite_write_ctrl #(.CH_S2MM(1'b0), .CR_VALUE(32'h0000_0001), .LEN_W(26)) dutMm2s (
    .clk(clk), .rst_n(rst_n), .start(start & sel), .buf_addr(bufAddr), .buf_len(bufLen),
    .m_axi_lite(bus1), .busy(busy1), .done(done1), .err(err1)
  );

  // Master-side mux: the slave only ever sees the selected controller
  logic [9:0]  awaddrM;
  logic        awvalidM, wvalidM, breadyM;
  logic [31:0] wdataM;
  logic [3:0]  wstrbM;
  logic        selBusy, selDone, selErr;

  assign awaddrM  = sel ? bus1.awaddr  : bus0.awaddr;
  assign awvalidM = sel ? bus1.awvalid : bus0.awvalid;
  assign wdataM   = sel ? bus1.wdata   : bus0.wdata;
  assign wstrbM   = sel ? bus1.wstrb   : bus0.wstrb;
  assign wvalidM  = sel ? bus1.wvalid  : bus0.wvalid;
  assign breadyM  = sel ? bus1.bready  : bus0.bready;
  assign selBusy  = sel ? busy1 : busy0;
  assign selDone  = sel ? done1 : done0;
  assign selErr   = sel ? err1  : err0;

  // Slave model configuration, set from the stimulus block
  int   awDelay = 0;
  int   wDelay  = 0;
  int   errIdx  = -1;
  logic earlyB  = 1'b0;

  int         awCnt, wCnt, wrCount;
  logic       sAw, sW, bvalidQ;
  logic [1:0] brespQ;
  logic       awreadyS, wreadyS, bvalidS, awHs, wHs;
  logic [1:0] brespS;
  logic [31:0] awLog[$];
  logic [31:0] wLog[$];
  int doneCnt = 0;
  int errCnt  = 0;
  int strbBad = 0;

  assign awreadyS = awvalidM && (awCnt >= awDelay);
  assign wreadyS  = wvalidM && (wCnt >= wDelay);
  assign awHs     = awvalidM && awreadyS;
  assign wHs      = wvalidM && wreadyS;
  assign bvalidS  = bvalidQ || (earlyB && awHs && wHs);
  assign brespS   = bvalidQ ? brespQ : ((wrCount == errIdx) ? RESP_SLVERR : RESP_OKAY);

  assign bus0.awready = awreadyS;
  assign bus0.wready  = wreadyS;
  assign bus0.bvalid  = bvalidS;
  assign bus0.bresp   = brespS;
  assign bus1.awready = awreadyS;
  assign bus1.wready  = wreadyS;
  assign bus1.bvalid  = bvalidS;
  assign bus1.bresp   = brespS;

  // Slave: count wait cycles per channel, log accepted beats, and raise a
  // response once both address and data of a write have been taken
  always @(posedge clk) begin
    if (!rst_n) begin
      awCnt   <= 0;
      wCnt    <= 0;
      sAw     <= 1'b0;
      sW      <= 1'b0;
      bvalidQ <= 1'b0;
      brespQ  <= RESP_OKAY;
      wrCount <= 0;
    end else begin
      if (awHs) begin
        awCnt <= 0;
        sAw   <= 1'b1;
        awLog.push_back(32'(awaddrM));
      end else if (awvalidM) begin
        awCnt <= awCnt + 1;
      end
      if (wHs) begin
        wCnt <= 0;
        sW   <= 1'b1;
        wLog.push_back(wdataM);
      end else if (wvalidM) begin
        wCnt <= wCnt + 1;
      end
      if (bvalidQ && breadyM) begin
        bvalidQ <= 1'b0;
      end else if (!bvalidQ && (sAw || awHs) && (sW || wHs)) begin
        bvalidQ <= 1'b1;
        brespQ  <= (wrCount == errIdx) ? RESP_SLVERR : RESP_OKAY;
        wrCount <= wrCount + 1;
        sAw     <= 1'b0;
        sW      <= 1'b0;
      end
    end
  end

  // Pulse counters and strobe watchdog across the whole run
  always @(posedge clk) begin
    doneCnt <= doneCnt + (done0 ? 1 : 0) + (done1 ? 1 : 0);
    errCnt  <= errCnt + (err0 ? 1 : 0) + (err1 ? 1 : 0);
    if ((wvalidM && wstrbM != 4'hF) || (!wvalidM && wstrbM != 4'h0))
      strbBad <= strbBad + 1;
  end

  int nAssert = 0;
  int nFail   = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nAssert++;
    assert (observed === expected) else begin
      nFail++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Pulse start for one cycle; returns at the negedge of the first busy cycle
  task automatic applyStimulus(input logic [31:0] addr, input logic [25:0] len);
    @(negedge clk);
    bufAddr = addr;
    bufLen  = len;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic waitResult(input int limit, output int cyc, output logic gotDone, output logic gotErr);
    cyc     = 1;
    gotDone = 1'b0;
    gotErr  = 1'b0;
    while (cyc <= limit) begin
      if (selDone || selErr) begin
        gotDone = selDone;
        gotErr  = selErr;
        break;
      end
      @(negedge clk);
      cyc++;
    end
  endtask

  function automatic logic [31:0] awAt(input int i);
    return (i < awLog.size()) ? awLog[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] wAt(input int i);
    return (i < wLog.size()) ? wLog[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic checkWrites(input string tag, input int base,
                             input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2,
                             input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
    checkOutput({tag, " aw count"}, 32'(awLog.size() - base), 32'd3);
    checkOutput({tag, " w count"},  32'(wLog.size() - base), 32'd3);
    checkOutput({tag, " aw0"}, awAt(base),     a0);
    checkOutput({tag, " aw1"}, awAt(base + 1), a1);
    checkOutput({tag, " aw2"}, awAt(base + 2), a2);
    checkOutput({tag, " w0"},  wAt(base),      d0);
    checkOutput({tag, " w1"},  wAt(base + 1),  d1);
    checkOutput({tag, " w2"},  wAt(base + 2),  d2);
  endtask

  initial begin
    int   base, cyc, dBase, eBase;
    int   awvCycles, wvCycles, breadyEarly, unstable;
    logic gotDone, gotErr, prevAwv, prevWv;
    logic [9:0]  prevAddr;
    logic [31:0] prevData;

    rst_n   = 1'b0;
    start   = 1'b0;
    sel     = 1'b0;
    bufAddr = '0;
    bufLen  = '0;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst awvalid", 32'(bus0.awvalid), 32'd0);
    checkOutput("rst wvalid",  32'(bus0.wvalid),  32'd0);
    checkOutput("rst bready",  32'(bus0.bready),  32'd0);
    checkOutput("rst awaddr",  32'(bus0.awaddr),  32'd0);
    checkOutput("rst wdata",   bus0.wdata,        32'd0);
    checkOutput("rst wstrb",   32'(bus0.wstrb),   32'd0);
    checkOutput("rst busy",    32'(busy0),        32'd0);
    checkOutput("rst done",    32'(done0),        32'd0);
    checkOutput("rst err",     32'(err0),         32'd0);
    checkOutput("rst busy mm2s", 32'(busy1),      32'd0);
    rst_n = 1'b1;

    // 1: zero-wait slave, S2MM, cycle-exact busy/done profile
    $display("[TB] test 1: zero-wait S2MM sequence");
    base  = awLog.size();
    dBase = doneCnt;
    applyStimulus(32'h1000_0000, 26'h400);
    for (int c = 1; c <= 14; c++) begin
      if (c > 1) @(negedge clk);
      checkOutput($sformatf("t1 busy c%0d", c), 32'(busy0), (c <= 13) ? 32'd1 : 32'd0);
      checkOutput($sformatf("t1 done c%0d", c), 32'(done0), (c == 14) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    checkOutput("t1 done pulse width", 32'(done0), 32'd0);
    checkWrites("t1", base, 32'h30, 32'h48, 32'h58, 32'h1, 32'h1000_0000, 32'h400);
    checkOutput("t1 done count", 32'(doneCnt - dBase), 32'd1);

    // 2: awready delayed, wready immediate
    $display("[TB] test 2: delayed awready");
    awDelay = 2;
    base    = awLog.size();
    awvCycles = 0; wvCycles = 0; breadyEarly = 0; unstable = 0;
    prevAwv = 1'b0; prevWv = 1'b0; prevAddr = '0; prevData = '0;
    applyStimulus(32'h1234_5678, 26'h100);
    for (int c = 0; c < 100 && !selDone; c++) begin
      if (awvalidM) awvCycles++;
      if (wvalidM) wvCycles++;
      if (breadyM && (awvalidM || wvalidM)) breadyEarly++;
      if (awvalidM && prevAwv && awaddrM != prevAddr) unstable++;
      if (wvalidM && prevWv && wdataM != prevData) unstable++;
      prevAwv = awvalidM; prevWv = wvalidM; prevAddr = awaddrM; prevData = wdataM;
      @(negedge clk);
    end
    checkOutput("t2 done seen", 32'(selDone), 32'd1);
    checkOutput("t2 awvalid cycles", 32'(awvCycles), 32'd9);
    checkOutput("t2 wvalid cycles", 32'(wvCycles), 32'd3);
    checkOutput("t2 bready before handshakes", 32'(breadyEarly), 32'd0);
    checkOutput("t2 payload changes", 32'(unstable), 32'd0);
    checkWrites("t2", base, 32'h30, 32'h48, 32'h58, 32'h1, 32'h1234_5678, 32'h100);
    awDelay = 0;

    // 3: SLVERR on the second write aborts the sequence
    $display("[TB] test 3: error response on write 2");
    @(negedge clk);
    errIdx = wrCount + 1;
    base   = awLog.size();
    dBase  = doneCnt;
    eBase  = errCnt;
    applyStimulus(32'h2222_0000, 26'h40);
    waitResult(40, cyc, gotDone, gotErr);
    checkOutput("t3 err seen", 32'(gotErr), 32'd1);
    checkOutput("t3 done not seen", 32'(gotDone), 32'd0);
    checkOutput("t3 err cycle", 32'(cyc), 32'd9);
    checkOutput("t3 busy during err", 32'(busy0), 32'd0);
    @(negedge clk);
    checkOutput("t3 err pulse width", 32'(err0), 32'd0);
    repeat (6) @(negedge clk);
    checkOutput("t3 aw count", 32'(awLog.size() - base), 32'd2);
    checkOutput("t3 w count", 32'(wLog.size() - base), 32'd2);
    checkOutput("t3 err count", 32'(errCnt - eBase), 32'd1);
    checkOutput("t3 done count", 32'(doneCnt - dBase), 32'd0);
    checkOutput("t3 idle busy", 32'(busy0), 32'd0);
    errIdx = -1;

    // 4: start re-pulsed while busy is ignored
    $display("[TB] test 4: start while busy");
    base  = awLog.size();
    dBase = doneCnt;
    applyStimulus(32'h2000_0000, 26'h80);
    @(negedge clk);
    @(negedge clk);
    bufAddr = 32'h3000_0000;
    bufLen  = 26'h10;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    waitResult(40, cyc, gotDone, gotErr);
    checkOutput("t4 done seen", 32'(gotDone), 32'd1);
    repeat (20) @(negedge clk);
    checkWrites("t4", base, 32'h30, 32'h48, 32'h58, 32'h1, 32'h2000_0000, 32'h80);
    checkOutput("t4 done count", 32'(doneCnt - dBase), 32'd1);
    checkOutput("t4 idle busy", 32'(busy0), 32'd0);

    // 5: reset during ISSUE of write 2, then a fresh run with buf_len=0
    $display("[TB] test 5: reset mid-sequence");
    awDelay = 3;
    base    = awLog.size();
    applyStimulus(32'h4444_0000, 26'h20);
    for (int c = 0; c < 60 && !(awLog.size() == base + 1 && awvalidM); c++) @(negedge clk);
    checkOutput("t5 reached write 2", 32'(awvalidM && awLog.size() == base + 1), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("t5 awvalid after rst", 32'(bus0.awvalid), 32'd0);
    checkOutput("t5 wvalid after rst",  32'(bus0.wvalid),  32'd0);
    checkOutput("t5 bready after rst",  32'(bus0.bready),  32'd0);
    checkOutput("t5 busy after rst",    32'(busy0),        32'd0);
    checkOutput("t5 aw count at rst",   32'(awLog.size() - base), 32'd1);
    rst_n   = 1'b1;
    awDelay = 0;
    base    = awLog.size();
    applyStimulus(32'h5000_0000, 26'h0);
    waitResult(40, cyc, gotDone, gotErr);
    checkOutput("t5 done seen", 32'(gotDone), 32'd1);
    checkOutput("t5 done cycle", 32'(cyc), 32'd14);
    checkWrites("t5", base, 32'h30, 32'h48, 32'h58, 32'h1, 32'h5000_0000, 32'h0);

    // 6: MM2S channel, B response raised with the last handshake
    $display("[TB] test 6: MM2S with early bvalid");
    @(negedge clk);
    sel    = 1'b1;
    earlyB = 1'b1;
    base   = awLog.size();
    applyStimulus(32'h4000_0000, 26'h3FF_FFFF);
    waitResult(40, cyc, gotDone, gotErr);
    checkOutput("t6 done seen", 32'(gotDone), 32'd1);
    checkOutput("t6 no err", 32'(gotErr), 32'd0);
    checkOutput("t6 done cycle", 32'(cyc), 32'd14);
    checkOutput("t6 s2mm idle", 32'(busy0), 32'd0);
    checkWrites("t6", base, 32'h00, 32'h18, 32'h28, 32'h1, 32'h4000_0000, 32'h03FF_FFFF);

    repeat (2) @(negedge clk);
    checkOutput("wstrb tracking wvalid", 32'(strbBad), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
